pll_ctrl: RTL

- Sequencer sitting beside the `pll` macro, clocked by `refclk`.
- Programs the feedback divider, drives the PLL's active-low reset and brake, and declares lock from sampled PFD up/down pulses.
- Reacts to supply-droop events by braking, then relocking.
- System logic may reprogram divn through a valid/ready handshake; `locked` gates downstream use of `pclk`.

---
 rtl/pll_ctrl.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_ctrl.sv
// pll_ctrl: reset, brake and lock-detect sequencer for the pll macro, clocked by refclk.
// Optional feature: define PLL_CTRL_AUTORETRY_EN to retry a timed-out lock with a full PLL reset.
module pll_ctrl #(
  parameter int DIVW          = 8,
  parameter int DIVN_RESET    = 27,
  parameter int RST_CYCLES    = 100,
  parameter int SETTLE_CYCLES = 256,
  parameter int WIN           = 64,
  parameter int TOL           = 4,
  parameter int LOCK_WINS     = 4,
  parameter int TIMEOUT_WINS  = 64,
  parameter int BRAKE_CYCLES  = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic            refclk,
  input  logic            reset,
  input  logic            en,
  input  logic            cfg_valid,
  input  logic [DIVW-1:0] cfg_divn,
  output logic            cfg_ready,
  input  logic            phase_up,
  input  logic            phase_dn,
  input  logic            droop,
  output logic            pll_resetn,
  output logic            brake,
  output logic [DIVW-1:0] divn,
  output logic            locked,
  output logic            fail,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST       = 3'd1,
    SETTLE    = 3'd2,
    LOCK_WAIT = 3'd3,
    LOCKED    = 3'd4,
    BRAKE     = 3'd5,
    FAIL      = 3'd6
  } state_t;

  localparam int TMAX = (RST_CYCLES > SETTLE_CYCLES)
                        ? ((RST_CYCLES > BRAKE_CYCLES) ? RST_CYCLES : BRAKE_CYCLES)
                        : ((SETTLE_CYCLES > BRAKE_CYCLES) ? SETTLE_CYCLES : BRAKE_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  localparam int WW = $clog2(WIN);
  localparam int DW = $clog2(WIN) + 2;
  localparam int GW = $clog2(LOCK_WINS + 1);
  localparam int OW = $clog2(TIMEOUT_WINS + 1);

  state_t                state, state_n;
  logic [TW-1:0]         tmr, tmr_n;
  logic [WW-1:0]         win_cnt, win_n;
  logic signed [DW-1:0]  diff, diff_n, diff_acc, step;
  logic [DW-1:0]         abs_diff;
  logic                  win_end, win_good;
  logic [GW-1:0]         good_cnt, good_n;
  logic [OW-1:0]         wins, wins_n;
  logic [DIVW-1:0]       divn_n;
  logic                  droop_q, droop_rise;
  logic                  cfg_acc;
  logic                  clr_mon;

`ifdef PLL_CTRL_AUTORETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_cnt, retry_n;
`else
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  // Handshake: a request transfers on any cycle where cfg_valid && cfg_ready are both
  // high; cfg_ready is a registered flag, high only in IDLE, LOCKED and FAIL.
  assign cfg_acc    = cfg_valid && cfg_ready;
  assign droop_rise = droop && !droop_q;
  assign state_o    = state;

  // Window arithmetic: up and down in the same cycle cancel.
  always_comb begin
    step = '0;
    if (phase_up && !phase_dn)
      step = DW'(1);
    else if (phase_dn && !phase_up)
      step = '1;
    diff_acc = diff + step;
    abs_diff = diff_acc[DW-1] ? DW'(-diff_acc) : DW'(diff_acc);
    win_end  = (win_cnt == WW'(WIN - 1));
    win_good = (abs_diff <= DW'(TOL));
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    win_n   = win_cnt;
    diff_n  = diff;
    good_n  = good_cnt;
    wins_n  = wins;
    divn_n  = divn;
    clr_mon = 1'b0;
`ifdef PLL_CTRL_AUTORETRY_EN
    retry_n = retry_cnt;
`endif

    case (state)
      IDLE: begin
        tmr_n   = '0;
        clr_mon = 1'b1;
`ifdef PLL_CTRL_AUTORETRY_EN
        retry_n = '0;
`endif
        if (en)
          state_n = RST;
      end

      RST: begin
        if (tmr == TW'(RST_CYCLES - 1)) begin
          state_n = SETTLE;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end

      SETTLE: begin
        if (tmr == TW'(SETTLE_CYCLES - 1)) begin
          state_n = LOCK_WAIT;
          tmr_n   = '0;
          clr_mon = 1'b1;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end

      LOCK_WAIT: begin
        win_n  = win_end ? '0 : win_cnt + WW'(1);
        diff_n = win_end ? '0 : diff_acc;
        if (win_end) begin
          good_n = win_good ? good_cnt + GW'(1) : '0;
          wins_n = wins + OW'(1);
          if (win_good && (good_cnt == GW'(LOCK_WINS - 1))) begin
            state_n = LOCKED;
            clr_mon = 1'b1;
`ifdef PLL_CTRL_AUTORETRY_EN
            retry_n = '0;
`endif
          end else if (wins == OW'(TIMEOUT_WINS - 1)) begin
`ifdef PLL_CTRL_AUTORETRY_EN
            if (retry_cnt == RW'(MAX_RETRY)) begin
              state_n = FAIL;
            end else begin
              retry_n = retry_cnt + RW'(1);
              state_n = RST;
              tmr_n   = '0;
              clr_mon = 1'b1;
            end
`else
            state_n = FAIL;
`endif
          end
        end
      end

      LOCKED: begin
        // A single bad window drops lock without touching the PLL itself.
        win_n  = win_end ? '0 : win_cnt + WW'(1);
        diff_n = win_end ? '0 : diff_acc;
        if (win_end && !win_good) begin
          state_n = LOCK_WAIT;
          clr_mon = 1'b1;
        end
      end

      BRAKE: begin
        if (tmr == TW'(BRAKE_CYCLES - 1)) begin
          state_n = LOCK_WAIT;
          tmr_n   = '0;
          clr_mon = 1'b1;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end

      FAIL: begin
        tmr_n = '0;
      end

      default: begin
        state_n = IDLE;
        tmr_n   = '0;
        clr_mon = 1'b1;
      end
    endcase

    // Overrides, lowest priority first. An accepted non-zero divider is always
    // captured so a transferred request is never lost, even if a higher-priority
    // event decides the next state.
    if (cfg_acc && (cfg_divn != '0)) begin
      divn_n  = cfg_divn;
      state_n = RST;
      tmr_n   = '0;
      clr_mon = 1'b1;
`ifdef PLL_CTRL_AUTORETRY_EN
      retry_n = '0;
`endif
    end

    if (droop_rise && ((state == SETTLE) || (state == LOCK_WAIT) ||
                       (state == LOCKED) || (state == BRAKE))) begin
      state_n = BRAKE;
      tmr_n   = '0;
      clr_mon = 1'b1;
    end

    if (!en) begin
      state_n = IDLE;
      tmr_n   = '0;
      clr_mon = 1'b1;
    end

    if (clr_mon) begin
      win_n  = '0;
      diff_n = '0;
      good_n = '0;
      wins_n = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state      <= IDLE;
      tmr        <= '0;
      win_cnt    <= '0;
      diff       <= '0;
      good_cnt   <= '0;
      wins       <= '0;
      divn       <= DIVW'(DIVN_RESET);
      droop_q    <= 1'b0;
      pll_resetn <= 1'b0;
      brake      <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      cfg_ready  <= 1'b0;
`ifdef PLL_CTRL_AUTORETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      state      <= state_n;
      tmr        <= tmr_n;
      win_cnt    <= win_n;
      diff       <= diff_n;
      good_cnt   <= good_n;
      wins       <= wins_n;
      divn       <= divn_n;
      droop_q    <= droop;
      pll_resetn <= (state_n == SETTLE) || (state_n == LOCK_WAIT) ||
                    (state_n == LOCKED) || (state_n == BRAKE);
      brake      <= (state_n == BRAKE);
      locked     <= (state_n == LOCKED);
      fail       <= (state_n == FAIL);
      cfg_ready  <= (state_n == IDLE) || (state_n == LOCKED) || (state_n == FAIL);
`ifdef PLL_CTRL_AUTORETRY_EN
      retry_cnt  <= retry_n;
`endif
    end
  end

endmodule
